// File: rtl/zstr_ser_pkg.sv
// ============================================================================
// zstr_ser_pkg : shared helpers for the zstr width-down serializer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package zstr_ser_pkg;

  function automatic int zs_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zstr_ser.sv
// ============================================================================
// zstr_ser : zstr width-down converter, one BW-bit word -> BW/SW SW-bit beats
// Revision : 1.0
// ============================================================================
`default_nettype none

module zstr_ser
  import zstr_ser_pkg::*;
#(
  parameter int BW = 32,
  parameter int SW = 8,
  parameter int LE = 1
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          zi_vld,
  input  logic [BW-1:0] zi_bus,
  output logic          zi_ack,
  output logic          zo_vld,
  output logic [SW-1:0] zo_bus,
  output logic          zo_lst,
  input  logic          zo_ack
);

  localparam int N  = BW / SW;
  localparam int CW = (N > 1) ? zs_clog2(N) : 1;

  if ((BW % SW) != 0 || (BW / SW) < 2) begin : g_cfg_err
    $error("zstr_ser: BW must be a multiple of SW with BW/SW >= 2");
  end

  logic [BW-1:0] r_sh;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [BW-1:0] w_sh_nxt;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_lst;

  if (LE != 0) begin : g_le
    assign zo_bus   = r_sh[SW-1:0];
    assign w_sh_nxt = r_sh >> SW;
  end else begin : g_be
    assign zo_bus   = r_sh[BW-1:BW-SW];
    assign w_sh_nxt = r_sh << SW;
  end

  assign w_lst      = r_busy & (r_cnt == CW'(N - 1));
  assign w_out_xfer = r_busy & zo_ack;
  // Accepting on the last beat's handshake keeps the output stream gap-free.
  assign zi_ack     = ~r_busy | (w_lst & zo_ack);
  assign w_in_xfer  = zi_vld & zi_ack;

  assign zo_vld = r_busy;
  assign zo_lst = w_lst;

  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_in_xfer) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (w_out_xfer) begin
      if (w_lst) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Data path carries no reset; validity is tracked by r_busy alone.
  always_ff @(posedge z_clk) begin
    if (w_in_xfer) begin
      r_sh <= zi_bus;
    end else if (w_out_xfer && !w_lst) begin
      r_sh <= w_sh_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zstr_ser.sv
// ============================================================================
// tb_zstr_ser : directed self-checking bench for zstr_ser (LE=1 and LE=0)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_zstr_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        zi_vld;
  logic [31:0] zi_bus;
  logic        zo_ack;
  logic        zi_ack, zo_vld, zo_lst;
  logic [7:0]  zo_bus;
  logic        be_zi_ack, be_zo_vld, be_zo_lst;
  logic [7:0]  be_zo_bus;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  zstr_ser #(.BW(32), .SW(8), .LE(1)) dut (
    .z_clk(clk), .z_rst(rst), .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(zi_ack),
    .zo_vld(zo_vld), .zo_bus(zo_bus), .zo_lst(zo_lst), .zo_ack(zo_ack)
  );

  zstr_ser #(.BW(32), .SW(8), .LE(0)) dut_be (
    .z_clk(clk), .z_rst(rst), .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(be_zi_ack),
    .zo_vld(be_zo_vld), .zo_bus(be_zo_bus), .zo_lst(be_zo_lst), .zo_ack(zo_ack)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; zi_vld = 1'b0; zi_bus = '0; zo_ack = 1'b1;
    cyc(); cyc();
    #1;
    tot_cnt++;
    if ({zo_vld, zo_lst, zi_ack} !== 3'b001)
      $display("FAIL reset_state: got vld/lst/ack=%b required 001", {zo_vld, zo_lst, zi_ack});
    else pass_cnt++;
    rst = 1'b0;
    // Make the DUT busy, then assert reset between clock edges.
    cyc(); zi_vld = 1'b1; zi_bus = 32'h44332211;
    cyc(); zi_vld = 1'b0;
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b1) $display("FAIL async_pre_busy: got vld=%b required 1", zo_vld);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    tot_cnt++;
    if ({zo_vld, zo_lst, zi_ack} !== 3'b001)
      $display("FAIL async_reset: got vld/lst/ack=%b required 001", {zo_vld, zo_lst, zi_ack});
    else pass_cnt++;
    cyc(); rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'h44332211;
    cyc(); zi_vld = 1'b1; zi_bus = w; zo_ack = 1'b1;
    #1;
    tot_cnt++;
    if (zi_ack !== 1'b1 || zo_vld !== 1'b0)
      $display("FAIL single_idle: got ack=%b vld=%b required ack=1 vld=0", zi_ack, zo_vld);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc(); zi_vld = 1'b0;
      #1;
      tot_cnt++;
      if (zo_vld !== 1'b1 || zo_bus !== w[8*i +: 8] || zo_lst !== (i == 3) || zi_ack !== (i == 3))
        $display("FAIL single_beat%0d: got vld=%b bus=%h lst=%b ack=%b required 1 %h %b %b",
                 i, zo_vld, zo_bus, zo_lst, zi_ack, w[8*i +: 8], (i == 3), (i == 3));
      else pass_cnt++;
    end
    cyc();
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b0) $display("FAIL single_done: got vld=%b required 0", zo_vld);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws;
    ws = {32'h88776655, 32'h44332211};
    cyc(); zi_vld = 1'b1; zi_bus = ws[31:0]; zo_ack = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cyc();
      zi_vld = (b < 4);
      zi_bus = ws[63:32];
      #1;
      tot_cnt++;
      if (zo_vld !== 1'b1 || zo_bus !== ws[8*b +: 8] || zo_lst !== (b == 3 || b == 7))
        $display("FAIL b2b_beat%0d: got vld=%b bus=%h lst=%b required 1 %h %b",
                 b, zo_vld, zo_bus, zo_lst, ws[8*b +: 8], (b == 3 || b == 7));
      else pass_cnt++;
      if (b == 3) begin
        tot_cnt++;
        if (zi_ack !== 1'b1) $display("FAIL b2b_accept: got ack=%b required 1", zi_ack);
        else pass_cnt++;
      end
    end
    cyc(); zi_vld = 1'b0;
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b0) $display("FAIL b2b_done: got vld=%b required 0", zo_vld);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = 32'h44332211;
    cyc(); zi_vld = 1'b1; zi_bus = w; zo_ack = 1'b1;
    cyc(); zi_vld = 1'b0;
    #1;
    tot_cnt++;
    if (zo_bus !== 8'h11) $display("FAIL stall_beat0: got bus=%h required 11", zo_bus);
    else pass_cnt++;
    for (int s = 0; s < 3; s++) begin
      cyc(); zo_ack = 1'b0;
      #1;
      tot_cnt++;
      if (zo_vld !== 1'b1 || zo_bus !== 8'h22 || zo_lst !== 1'b0)
        $display("FAIL stall_hold%0d: got vld=%b bus=%h lst=%b required 1 22 0", s, zo_vld, zo_bus, zo_lst);
      else pass_cnt++;
    end
    for (int i = 1; i < 4; i++) begin
      cyc(); zo_ack = 1'b1;
      #1;
      tot_cnt++;
      if (zo_vld !== 1'b1 || zo_bus !== w[8*i +: 8] || zo_lst !== (i == 3))
        $display("FAIL stall_resume%0d: got vld=%b bus=%h lst=%b required 1 %h %b",
                 i, zo_vld, zo_bus, zo_lst, w[8*i +: 8], (i == 3));
      else pass_cnt++;
    end
    cyc();
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b0) $display("FAIL stall_done: got vld=%b required 0", zo_vld);
    else pass_cnt++;
  endtask

  task automatic test_big_endian();
    logic [31:0] exp_be;
    exp_be = 32'h11223344;
    cyc(); zi_vld = 1'b1; zi_bus = 32'h44332211; zo_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); zi_vld = 1'b0;
      #1;
      tot_cnt++;
      if (be_zo_vld !== 1'b1 || be_zo_bus !== exp_be[8*i +: 8] || be_zo_lst !== (i == 3))
        $display("FAIL be_beat%0d: got vld=%b bus=%h lst=%b required 1 %h %b",
                 i, be_zo_vld, be_zo_bus, be_zo_lst, exp_be[8*i +: 8], (i == 3));
      else pass_cnt++;
    end
    cyc();
    #1;
    tot_cnt++;
    if (be_zo_vld !== 1'b0 || be_zi_ack !== 1'b1)
      $display("FAIL be_done: got vld=%b ack=%b required 0 1", be_zo_vld, be_zi_ack);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    w = 32'hDDCCBBAA;
    cyc(); zi_vld = 1'b1; zi_bus = 32'h44332211; zo_ack = 1'b1;
    cyc(); zi_vld = 1'b0;
    cyc();
    cyc();
    #1;
    tot_cnt++;
    if (zo_bus !== 8'h33) $display("FAIL rstmid_pre: got bus=%h required 33", zo_bus);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b0 || zo_lst !== 1'b0)
      $display("FAIL rstmid_drop: got vld=%b lst=%b required 0 0", zo_vld, zo_lst);
    else pass_cnt++;
    cyc();
    #1;
    tot_cnt++;
    if (zo_vld !== 1'b0) $display("FAIL rstmid_hold: got vld=%b required 0", zo_vld);
    else pass_cnt++;
    cyc(); rst = 1'b0; zi_vld = 1'b1; zi_bus = w;
    #1;
    tot_cnt++;
    if (zi_ack !== 1'b1) $display("FAIL rstmid_accept: got ack=%b required 1", zi_ack);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc(); zi_vld = 1'b0;
      #1;
      tot_cnt++;
      if (zo_vld !== 1'b1 || zo_bus !== w[8*i +: 8] || zo_lst !== (i == 3))
        $display("FAIL rstmid_beat%0d: got vld=%b bus=%h lst=%b required 1 %h %b",
                 i, zo_vld, zo_bus, zo_lst, w[8*i +: 8], (i == 3));
      else pass_cnt++;
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_big_endian();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

`default_nettype wire
